// File: rtl/parking_gate_arbiter_pkg.sv
// Types and default constants shared by the gate arbiter and the display logic.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN_IN,
    OPEN_OUT,
    GUARD
  } gate_state_t;

  typedef enum logic {
    ENTRY,
    EXIT
  } lane_t;

  localparam int DEF_CAPACITY     = 8;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_OPEN_CYCLES  = 250_000_000;
  localparam int DEF_GUARD_CYCLES = 25_000_000;
  localparam int DEF_TMR_W        = 28;

  // On a tie the lane that was not served last wins.
  function automatic lane_t pick_lane(input logic ent_ok, input logic ext_ok,
                                      input lane_t last_served);
    if (ent_ok && ext_ok) return (last_served == EXIT) ? ENTRY : EXIT;
    else if (ent_ok)      return ENTRY;
    else                  return EXIT;
  endfunction

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Request/grant/status bundle between the front end, the arbiter and the display.
interface parking_gate_arbiter_if
  import parking_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             entry_req;
  logic             exit_req;
  logic             pass_done;
  logic             grant_entry;
  logic             grant_exit;
  logic             gate_open;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             timeout_err;

  modport master (
    output entry_req, exit_req, pass_done,
    input  grant_entry, grant_exit, gate_open, occupancy, full, empty, timeout_err
  );

  modport slave (
    input  entry_req, exit_req, pass_done,
    output grant_entry, grant_exit, gate_open, occupancy, full, empty, timeout_err
  );
endinterface

// File: rtl/parking_gate_arbiter_timer.sv
// Shared window timer: up-counter with synchronous clear and terminal-count flag.
module gate_timer #(
  parameter int TMR_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [TMR_W-1:0] tc_val,
  output logic             tc
);
  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else              count <= count + TMR_W'(1);
  end

  assign tc = (count == tc_val);
endmodule

// File: rtl/parking_gate_arbiter.sv
// Arbitrates the shared barrier between entrance and exit lanes and tracks occupancy.
// state    | meaning
// IDLE     | gate closed, sampling eligible requests
// OPEN_IN  | entrance owns the gate, waiting for pass_done or window expiry
// OPEN_OUT | exit owns the gate, waiting for pass_done or window expiry
// GUARD    | gate held closed for the guard interval, requests ignored
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int TMR_W        = DEF_TMR_W
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  parking_gate_arbiter_if.slave bus
);
  localparam logic [TMR_W-1:0] OPEN_TC  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] GUARD_TC = TMR_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

  gate_state_t      state, state_nxt;
  lane_t            last_served, last_nxt, lane_sel;
  logic [CNT_W-1:0] occ_q, occ_nxt;
  logic             full, empty, ent_ok, ext_ok;
  logic             tmr_clr, tmr_tc, timeout;
  logic [TMR_W-1:0] tc_val;
  logic             grant_entry_q, grant_exit_q, gate_open_q;

  assign full     = (occ_q == CAP);
  assign empty    = (occ_q == '0);
  assign ent_ok   = bus.entry_req && !full;
  assign ext_ok   = bus.exit_req && !empty;
  assign lane_sel = pick_lane(ent_ok, ext_ok, last_served);
  assign tc_val   = (state == GUARD) ? GUARD_TC : OPEN_TC;

  gate_timer #(.TMR_W(TMR_W)) u_timer (
    .clk    (CLOCK_50),
    .reset  (reset),
    .clr    (tmr_clr),
    .tc_val (tc_val),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last_served;
    occ_nxt   = occ_q;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (ent_ok || ext_ok) begin
          state_nxt = (lane_sel == ENTRY) ? OPEN_IN : OPEN_OUT;
          last_nxt  = lane_sel;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        // pass_done takes priority over a coincident window expiry
        if (bus.pass_done) begin
          occ_nxt   = (state == OPEN_IN) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
          state_nxt = GUARD;
        end else if (tmr_tc) begin
          timeout   = 1'b1;
          state_nxt = GUARD;
        end
      end
      GUARD: begin
        if (tmr_tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    tmr_clr = (state_nxt != state);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      last_served   <= EXIT;
      occ_q         <= '0;
      grant_entry_q <= 1'b0;
      grant_exit_q  <= 1'b0;
      gate_open_q   <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_served   <= last_nxt;
      occ_q         <= occ_nxt;
      grant_entry_q <= (state_nxt == OPEN_IN);
      grant_exit_q  <= (state_nxt == OPEN_OUT);
      gate_open_q   <= (state_nxt == OPEN_IN) || (state_nxt == OPEN_OUT);
    end
  end

  assign bus.grant_entry = grant_entry_q;
  assign bus.grant_exit  = grant_exit_q;
  assign bus.gate_open   = gate_open_q;
  assign bus.occupancy   = occ_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.timeout_err = timeout;
endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Sequences the single shared barrier gate of the parking system between two requesters: the entrance lane and the exit lane.
- Grants the gate to one lane at a time, times the open window and tracks lot occupancy against capacity.
- Sits between the sensor/password front end, which supplies validated requests, and the LED/7-segment display logic, which consumes grants, gate state and occupancy.

Parameters:
CAPACITY, 8, maximum number of parked cars; range 1..(2**CNT_W)-1.
CNT_W, 4, width of the occupancy counter.
OPEN_CYCLES, 250000000, clock cycles the gate stays open waiting for the car (5 s at 50 MHz).
GUARD_CYCLES, 25000000, clock cycles the gate is held closed after each grant ends.
TMR_W, 28, timer width; must hold max(OPEN_CYCLES, GUARD_CYCLES).

Ports:
CLOCK_50  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
entry_req  in  1  level; a car with a validated password is waiting at the entrance.
exit_req  in  1  level; a car is waiting at the exit.
pass_done  in  1  one-cycle pulse; the granted car has cleared the gate sensor.
grant_entry  out  1  registered; the entrance lane owns the gate.
grant_exit  out  1  registered; the exit lane owns the gate.
gate_open  out  1  registered; barrier raised.
occupancy  out  CNT_W  registered count of parked cars.
full  out  1  occupancy == CAPACITY.
empty  out  1  occupancy == 0.
timeout_err  out  1  one-cycle pulse; the open window expired with no pass_done.

Behaviour:
- Single clock domain, CLOCK_50. Reset is synchronous, active-high, and dominates all other inputs.
- Reset values:
  - grant_entry, grant_exit, gate_open, timeout_err = 0.
  - occupancy = 0, full = 0, empty = 1.
  - FSM = IDLE, timer = 0, last_served = EXIT, so entry wins the first tie.
- Eligibility: ent_ok = entry_req && !full; ext_ok = exit_req && !empty.
- FSM states: IDLE, OPEN_IN, OPEN_OUT, GUARD.
- IDLE:
  - Only ent_ok -> OPEN_IN. Only ext_ok -> OPEN_OUT.
  - Both -> serve the lane opposite to last_served.
  - Neither -> stay in IDLE.
  - Grant and gate_open rise on the clock edge after eligibility is sampled (1-cycle latency).
  - On leaving IDLE: timer cleared, last_served updated.
- OPEN_IN / OPEN_OUT:
  - Matching grant = 1, gate_open = 1; the timer increments every cycle.
  - pass_done -> occupancy +1 (OPEN_IN) or -1 (OPEN_OUT), visible the next cycle; go to GUARD.
  - timer == OPEN_CYCLES-1 with no pass_done -> timeout_err = 1 for one cycle, occupancy unchanged, go to GUARD.
  - gate_open is therefore high for exactly OPEN_CYCLES cycles on a timeout.
  - pass_done in the same cycle as expiry: pass_done wins and no timeout_err is raised.
  - Request withdrawn during the grant: the grant is held until pass_done or timeout.
- GUARD:
  - All grants and gate_open = 0 for exactly GUARD_CYCLES cycles, then IDLE.
  - Requests are not sampled during GUARD.
- pass_done is ignored in IDLE and GUARD.
- Occupancy never wraps, because full and empty gate eligibility. full and empty are decoded from the occupancy register, so they update in the same cycle as occupancy.
- Reset mid-grant: all outputs return to their reset values on the next edge; an in-flight pass_done is discarded.

Decomposition:
- Package parking_pkg holds:
  - the gate_state_t enum (IDLE, OPEN_IN, OPEN_OUT, GUARD);
  - the lane_t enum (ENTRY, EXIT) for last_served;
  - default CAPACITY and cycle constants shared with the display logic.
- Sub-module gate_timer: a TMR_W up-counter with synchronous clear and a terminal-count compare input. It is used for both the open window and the guard interval.

Test Plan (CAPACITY=2, OPEN_CYCLES=8, GUARD_CYCLES=2, CNT_W=4, TMR_W=4):
1. Reset, then entry_req=1 at cycle 0 -> grant_entry=1 and gate_open=1 at cycle 1. pass_done at cycle 4 -> occupancy=1 and gate_open=0 at cycle 5; empty=0; IDLE reached at cycle 7.
2. Occupancy=1, last_served=ENTRY, entry_req=exit_req=1 together:
   - grant_exit first, then occupancy=0.
   - After GUARD, exit_req is ignored because empty=1, and grant_entry follows.
3. Admit two cars -> occupancy=2, full=1. A further entry_req=1 keeps grant_entry=0 indefinitely. exit_req=1 -> grant_exit next cycle.
4. entry_req=1 with no pass_done -> gate_open high for exactly 8 cycles, timeout_err a single pulse in the last open cycle, occupancy unchanged.
5. Assert reset during OPEN_IN with pass_done in the same cycle -> next cycle all outputs 0, occupancy=0, empty=1, FSM in IDLE.
6. pass_done pulses in IDLE and in GUARD -> occupancy unchanged and no grant issued.
